ex_branch_hazard_unit: RTL and testbench
========================================

Name: ex_branch_hazard_unit

Overview:
- Combined EX-stage arithmetic and ID-stage branch-hazard block for the 5-stage MIPS pipeline.
- Contains the EX ALU and an internal EX/MEM result register.
- Branch operands are forwarded from that register into the ID-stage beq comparator.
- Raises a branch bubble (stall) when a branch operand cannot yet be forwarded.

Parameters:
DATA_W, 32, datapath width of ALU operands/results and branch operands
REG_AW, 5, register-number width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
ex_alu_a  input  DATA_W  ALU operand A (already forwarded)
ex_alu_b  input  DATA_W  ALU operand B (after ALUsrc mux)
ex_aluctr  input  3  ALU operation select
ex_rw  input  REG_AW  EX destination register (after RegDst mux)
ex_regwr  input  1  EX instruction writes a register
ex_memtoreg  input  1  EX instruction is a load
ex_result  output  DATA_W  combinational ALU result
ex_zero  output  1  combinational, 1 when ex_result == 0
mem_alu_result  output  DATA_W  registered ALU result
mem_zero  output  1  registered zero flag
mem_rw  output  REG_AW  registered destination register
mem_regwr  output  1  registered RegWr
mem_memtoreg  output  1  registered MemtoReg
id_ra  input  REG_AW  ID rs field
id_rb  input  REG_AW  ID rt field
id_busa  input  DATA_W  register-file read A
id_busb  input  DATA_W  register-file read B
id_branch  input  1  ID instruction is beq
branch_fwd_a  output  1  id_busa replaced by mem_alu_result
branch_fwd_b  output  1  id_busb replaced by mem_alu_result
branch_ok  output  1  beq taken
branch_bubble  output  1  stall ID/IF and insert bubble into EX

Behaviour:
- ALU, combinational, 2's-complement, results truncated to DATA_W:
  - 000 ADD: a+b
  - 001 SUB: a-b
  - 010 AND
  - 011 OR
  - 100 SLT: signed a<b gives 1, else 0
  - 101 SLTU: unsigned a<b
  - 110 XOR
  - 111 NOR
- ex_zero = (ex_result == 0) for every opcode.
- EX/MEM register:
  - On each rising clk, captures ex_result, ex_zero, ex_rw, ex_regwr, ex_memtoreg into the mem_* outputs.
  - No enable and no flush; callers convert a bubble to regwr=0 upstream.
  - rst low clears all mem_* outputs to 0 immediately, independent of clk, and holds them at 0 while low.
- Branch forwarding, combinational:
  - branch_fwd_a = mem_regwr & ~mem_memtoreg & (mem_rw != 0) & (mem_rw == id_ra).
  - branch_fwd_b is the same with id_rb.
  - Compared operands: opA = branch_fwd_a ? mem_alu_result : id_busa; opB likewise.
- Branch resolution: branch_ok = id_branch & (opA == opB). branch_ok is 0 whenever id_branch = 0.
- Branch bubble, combinational, asserted when id_branch is 1 and any of:
  - ex_regwr & (ex_rw != 0) & (ex_rw == id_ra or ex_rw == id_rb), meaning the ALU result is not yet available in ID;
  - mem_regwr & mem_memtoreg & (mem_rw != 0) & (mem_rw == id_ra or mem_rw == id_rb), meaning load data is not yet available.
- While branch_bubble = 1, branch_ok may be asserted from stale operands; the pipeline ignores branch_ok during a bubble.
- Register $0 never forwards and never causes a bubble.
- If both EX and MEM match, the bubble wins. Forwarding of the MEM value applies only once EX no longer matches.
- During reset, the mem_* outputs are 0, so no forwarding is driven from the register.

Optional Feature:
- Macro ALU_OVERFLOW_EN. When defined, adds two outputs:
  - ex_ovf (combinational): signed overflow for ADD/SUB only; 0 for other ops. ADD: a,b same sign and result sign differs. SUB: a,b differ in sign and result sign differs from a.
  - mem_ovf: registered with the same timing and reset as mem_zero.
- ex_ovf is a flag only; the result is still the wrapped value.
- When the macro is undefined, neither port exists and the behaviour is otherwise identical.

Test Plan:
- Reset: rst=0 mid-cycle -> all mem_* = 0 immediately. Release, apply a=5, b=3, ctr=000, clock -> mem_alu_result=8, mem_zero=0.
- ALU sweep with a=0xFFFFFFFF, b=1:
  - ADD gives 0 with ex_zero=1.
  - SLT gives 1.
  - SLTU gives 0.
  - NOR gives 0.
  - SUB of 7-7 gives 0 with ex_zero=1.
- Forwarding: mem_regwr=1, mem_memtoreg=0, mem_rw=8, mem_alu_result=0x10; id_ra=8, id_busa=0, id_busb=0x10, id_branch=1 -> branch_fwd_a=1, branch_ok=1, branch_bubble=0.
- EX hazard: ex_regwr=1, ex_rw=9, id_rb=9, id_branch=1 -> branch_bubble=1. Same with id_branch=0 -> bubble=0, branch_ok=0.
- Load hazard: mem_regwr=1, mem_memtoreg=1, mem_rw=4, id_ra=4, id_branch=1 -> branch_bubble=1, branch_fwd_a=0. Same with rw=0 -> bubble=0.
- With ALU_OVERFLOW_EN: ADD 0x7FFFFFFF+1 -> ex_ovf=1, result 0x80000000, mem_ovf=1 after the clock edge.

Source files
------------

// File: rtl/ex_branch_hazard_unit.sv
// EX-stage ALU with EX/MEM result register, plus ID-stage beq forwarding/compare and branch-bubble detection.
// Optional ALU_OVERFLOW_EN adds signed-overflow flags ex_ovf / mem_ovf.
module ex_branch_hazard_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] ex_alu_a,
  input  logic [DATA_W-1:0] ex_alu_b,
  input  logic [2:0]        ex_aluctr,
  input  logic [REG_AW-1:0] ex_rw,
  input  logic              ex_regwr,
  input  logic              ex_memtoreg,
  output logic [DATA_W-1:0] ex_result,
  output logic              ex_zero,
`ifdef ALU_OVERFLOW_EN
  output logic              ex_ovf,
  output logic              mem_ovf,
`endif
  output logic [DATA_W-1:0] mem_alu_result,
  output logic              mem_zero,
  output logic [REG_AW-1:0] mem_rw,
  output logic              mem_regwr,
  output logic              mem_memtoreg,
  input  logic [REG_AW-1:0] id_ra,
  input  logic [REG_AW-1:0] id_rb,
  input  logic [DATA_W-1:0] id_busa,
  input  logic [DATA_W-1:0] id_busb,
  input  logic              id_branch,
  output logic              branch_fwd_a,
  output logic              branch_fwd_b,
  output logic              branch_ok,
  output logic              branch_bubble
);

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_SLT  = 3'b100,
    ALU_SLTU = 3'b101,
    ALU_XOR  = 3'b110,
    ALU_NOR  = 3'b111
  } alu_op_e;

  alu_op_e           op;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              ex_hit;
  logic              load_hit;

  assign op = alu_op_e'(ex_aluctr);

  always_comb begin
    ex_result = '0;
    unique case (op)
      ALU_ADD:  ex_result = ex_alu_a + ex_alu_b;
      ALU_SUB:  ex_result = ex_alu_a - ex_alu_b;
      ALU_AND:  ex_result = ex_alu_a & ex_alu_b;
      ALU_OR:   ex_result = ex_alu_a | ex_alu_b;
      ALU_SLT:  ex_result = {{(DATA_W-1){1'b0}}, $signed(ex_alu_a) < $signed(ex_alu_b)};
      ALU_SLTU: ex_result = {{(DATA_W-1){1'b0}}, ex_alu_a < ex_alu_b};
      ALU_XOR:  ex_result = ex_alu_a ^ ex_alu_b;
      ALU_NOR:  ex_result = ~(ex_alu_a | ex_alu_b);
      default:  ex_result = '0;
    endcase
  end

  assign ex_zero = (ex_result == '0);

`ifdef ALU_OVERFLOW_EN
  always_comb begin
    ex_ovf = 1'b0;
    if (op == ALU_ADD)
      ex_ovf = (ex_alu_a[DATA_W-1] == ex_alu_b[DATA_W-1]) &&
               (ex_result[DATA_W-1] != ex_alu_a[DATA_W-1]);
    else if (op == ALU_SUB)
      ex_ovf = (ex_alu_a[DATA_W-1] != ex_alu_b[DATA_W-1]) &&
               (ex_result[DATA_W-1] != ex_alu_a[DATA_W-1]);
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_alu_result <= '0;
      mem_zero       <= 1'b0;
      mem_rw         <= '0;
      mem_regwr      <= 1'b0;
      mem_memtoreg   <= 1'b0;
`ifdef ALU_OVERFLOW_EN
      mem_ovf        <= 1'b0;
`endif
    end else begin
      mem_alu_result <= ex_result;
      mem_zero       <= ex_zero;
      mem_rw         <= ex_rw;
      mem_regwr      <= ex_regwr;
      mem_memtoreg   <= ex_memtoreg;
`ifdef ALU_OVERFLOW_EN
      mem_ovf        <= ex_ovf;
`endif
    end
  end

  // Only non-load MEM results can be forwarded; load data arrives a stage later.
  assign branch_fwd_a = mem_regwr && !mem_memtoreg && (mem_rw != '0) && (mem_rw == id_ra);
  assign branch_fwd_b = mem_regwr && !mem_memtoreg && (mem_rw != '0) && (mem_rw == id_rb);

  assign opa = branch_fwd_a ? mem_alu_result : id_busa;
  assign opb = branch_fwd_b ? mem_alu_result : id_busb;

  assign branch_ok = id_branch && (opa == opb);

  assign ex_hit   = ex_regwr && (ex_rw != '0) && ((ex_rw == id_ra) || (ex_rw == id_rb));
  assign load_hit = mem_regwr && mem_memtoreg && (mem_rw != '0) &&
                    ((mem_rw == id_ra) || (mem_rw == id_rb));

  assign branch_bubble = id_branch && (ex_hit || load_hit);

endmodule

// File: tb/tb_ex_branch_hazard_unit.sv
// Directed table-driven bench for ex_branch_hazard_unit: reset, ALU sweep, branch forward/bubble cases.
module tb_ex_branch_hazard_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ex_alu_a = '0;
  logic [31:0] ex_alu_b = '0;
  logic [2:0]  ex_aluctr = '0;
  logic [4:0]  ex_rw = '0;
  logic        ex_regwr = 1'b0;
  logic        ex_memtoreg = 1'b0;
  logic [31:0] ex_result;
  logic        ex_zero;
`ifdef ALU_OVERFLOW_EN
  logic        ex_ovf;
  logic        mem_ovf;
`endif
  logic [31:0] mem_alu_result;
  logic        mem_zero;
  logic [4:0]  mem_rw;
  logic        mem_regwr;
  logic        mem_memtoreg;
  logic [4:0]  id_ra = '0;
  logic [4:0]  id_rb = '0;
  logic [31:0] id_busa = '0;
  logic [31:0] id_busb = '0;
  logic        id_branch = 1'b0;
  logic        branch_fwd_a;
  logic        branch_fwd_b;
  logic        branch_ok;
  logic        branch_bubble;

  int passed = 0;
  int total  = 0;

  ex_branch_hazard_unit #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .ex_alu_a(ex_alu_a), .ex_alu_b(ex_alu_b), .ex_aluctr(ex_aluctr),
    .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .ex_result(ex_result), .ex_zero(ex_zero),
`ifdef ALU_OVERFLOW_EN
    .ex_ovf(ex_ovf), .mem_ovf(mem_ovf),
`endif
    .mem_alu_result(mem_alu_result), .mem_zero(mem_zero), .mem_rw(mem_rw),
    .mem_regwr(mem_regwr), .mem_memtoreg(mem_memtoreg),
    .id_ra(id_ra), .id_rb(id_rb), .id_busa(id_busa), .id_busb(id_busb),
    .id_branch(id_branch),
    .branch_fwd_a(branch_fwd_a), .branch_fwd_b(branch_fwd_b),
    .branch_ok(branch_ok), .branch_bubble(branch_bubble)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ctr;
    logic [31:0] res;
    logic        zero;
    logic        ovf;
  } alu_vec_t;

  typedef struct {
    logic [31:0] m_val;
    logic [4:0]  m_rw;
    logic        m_regwr;
    logic        m_mtr;
    logic [4:0]  e_rw;
    logic        e_regwr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] busa;
    logic [31:0] busb;
    logic        br;
    logic        fwd_a;
    logic        fwd_b;
    logic        ok;
    logic        bubble;
  } br_vec_t;

  alu_vec_t alu_tab[13];
  br_vec_t  br_tab[11];

  initial begin
    //            a             b             ctr     result        z     ovf
    alu_tab[0]  = '{32'hFFFFFFFF, 32'h00000001, 3'b000, 32'h00000000, 1'b1, 1'b0};
    alu_tab[1]  = '{32'hFFFFFFFF, 32'h00000001, 3'b001, 32'hFFFFFFFE, 1'b0, 1'b0};
    alu_tab[2]  = '{32'hFFFFFFFF, 32'h00000001, 3'b010, 32'h00000001, 1'b0, 1'b0};
    alu_tab[3]  = '{32'hFFFFFFFF, 32'h00000001, 3'b011, 32'hFFFFFFFF, 1'b0, 1'b0};
    alu_tab[4]  = '{32'hFFFFFFFF, 32'h00000001, 3'b100, 32'h00000001, 1'b0, 1'b0};
    alu_tab[5]  = '{32'hFFFFFFFF, 32'h00000001, 3'b101, 32'h00000000, 1'b1, 1'b0};
    alu_tab[6]  = '{32'hFFFFFFFF, 32'h00000001, 3'b110, 32'hFFFFFFFE, 1'b0, 1'b0};
    alu_tab[7]  = '{32'hFFFFFFFF, 32'h00000001, 3'b111, 32'h00000000, 1'b1, 1'b0};
    alu_tab[8]  = '{32'h00000007, 32'h00000007, 3'b001, 32'h00000000, 1'b1, 1'b0};
    alu_tab[9]  = '{32'h00000001, 32'hFFFFFFFF, 3'b100, 32'h00000000, 1'b1, 1'b0};
    alu_tab[10] = '{32'h00000001, 32'hFFFFFFFF, 3'b101, 32'h00000001, 1'b0, 1'b0};
    alu_tab[11] = '{32'h7FFFFFFF, 32'h00000001, 3'b000, 32'h80000000, 1'b0, 1'b1};
    alu_tab[12] = '{32'h80000000, 32'h00000001, 3'b001, 32'h7FFFFFFF, 1'b0, 1'b1};

    //           m_val         m_rw  mrw   mtr   e_rw  erw   ra    rb    busa          busb          br    fa    fb    ok    bub
    br_tab[0]  = '{32'h00000010, 5'd8, 1'b1, 1'b0, 5'd0, 1'b0, 5'd8, 5'd2, 32'h00000000, 32'h00000010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    br_tab[1]  = '{32'h00000000, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd1, 5'd9, 32'h00000005, 32'h00000006, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[2]  = '{32'h00000000, 5'd0, 1'b0, 1'b0, 5'd9, 1'b1, 5'd1, 5'd9, 32'h00000005, 32'h00000005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    br_tab[3]  = '{32'h00000020, 5'd4, 1'b1, 1'b1, 5'd0, 1'b0, 5'd4, 5'd5, 32'h00000007, 32'h00000008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    br_tab[4]  = '{32'h00000020, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0, 5'd5, 32'h00000003, 32'h00000003, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    br_tab[5]  = '{32'h00000010, 5'd8, 1'b1, 1'b0, 5'd8, 1'b1, 5'd8, 5'd3, 32'h00000000, 32'h00000011, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    br_tab[6]  = '{32'h00000000, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 32'h00000001, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    br_tab[7]  = '{32'h00000055, 5'd12, 1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 5'd12, 32'h00000055, 32'h00000000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    br_tab[8]  = '{32'h00000009, 5'd6, 1'b1, 1'b0, 5'd0, 1'b0, 5'd6, 5'd6, 32'h00000001, 32'h00000002, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    br_tab[9]  = '{32'h00000010, 5'd8, 1'b0, 1'b0, 5'd0, 1'b0, 5'd8, 5'd2, 32'h00000000, 32'h00000010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    br_tab[10] = '{32'h00000010, 5'd8, 1'b1, 1'b0, 5'd10, 1'b1, 5'd8, 5'd2, 32'h00000000, 32'h00000010, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

    // Reset: load non-zero state, then assert rst mid-cycle.
    tick();
    ex_alu_a = 32'd5; ex_alu_b = 32'd3; ex_aluctr = 3'b000;
    ex_rw = 5'd3; ex_regwr = 1'b1; ex_memtoreg = 1'b1;
    tick();
    check("pre-reset mem_alu_result", mem_alu_result, 32'd8);
    #2 rst = 1'b0;
    #1;
    check("reset mem_alu_result", mem_alu_result, 32'd0);
    check("reset mem_zero", {31'd0, mem_zero}, 32'd0);
    check("reset mem_rw", {27'd0, mem_rw}, 32'd0);
    check("reset mem_regwr", {31'd0, mem_regwr}, 32'd0);
    check("reset mem_memtoreg", {31'd0, mem_memtoreg}, 32'd0);
    tick();
    check("reset hold mem_alu_result", mem_alu_result, 32'd0);
    check("reset hold mem_regwr", {31'd0, mem_regwr}, 32'd0);
    rst = 1'b1;
    ex_regwr = 1'b0; ex_memtoreg = 1'b0; ex_rw = 5'd0;
    tick();
    check("post-reset mem_alu_result", mem_alu_result, 32'd8);
    check("post-reset mem_zero", {31'd0, mem_zero}, 32'd0);

    // ALU sweep: combinational then registered.
    for (int i = 0; i < 13; i++) begin
      ex_alu_a = alu_tab[i].a; ex_alu_b = alu_tab[i].b; ex_aluctr = alu_tab[i].ctr;
      ex_rw = 5'(i); ex_regwr = 1'b1; ex_memtoreg = i[0];
      #1;
      check($sformatf("alu[%0d] ex_result", i), ex_result, alu_tab[i].res);
      check($sformatf("alu[%0d] ex_zero", i), {31'd0, ex_zero}, {31'd0, alu_tab[i].zero});
`ifdef ALU_OVERFLOW_EN
      check($sformatf("alu[%0d] ex_ovf", i), {31'd0, ex_ovf}, {31'd0, alu_tab[i].ovf});
`endif
      tick();
      check($sformatf("alu[%0d] mem_alu_result", i), mem_alu_result, alu_tab[i].res);
      check($sformatf("alu[%0d] mem_zero", i), {31'd0, mem_zero}, {31'd0, alu_tab[i].zero});
      check($sformatf("alu[%0d] mem_rw", i), {27'd0, mem_rw}, i);
      check($sformatf("alu[%0d] mem_memtoreg", i), {31'd0, mem_memtoreg}, {31'd0, i[0]});
`ifdef ALU_OVERFLOW_EN
      check($sformatf("alu[%0d] mem_ovf", i), {31'd0, mem_ovf}, {31'd0, alu_tab[i].ovf});
`endif
    end

    // Branch cases: preload EX/MEM via one clock, then present EX/ID inputs.
    for (int i = 0; i < 11; i++) begin
      id_branch = 1'b0;
      ex_alu_a = br_tab[i].m_val; ex_alu_b = '0; ex_aluctr = 3'b000;
      ex_rw = br_tab[i].m_rw; ex_regwr = br_tab[i].m_regwr; ex_memtoreg = br_tab[i].m_mtr;
      tick();
      ex_rw = br_tab[i].e_rw; ex_regwr = br_tab[i].e_regwr; ex_memtoreg = 1'b0;
      ex_alu_a = 32'hDEAD0000;
      id_ra = br_tab[i].ra; id_rb = br_tab[i].rb;
      id_busa = br_tab[i].busa; id_busb = br_tab[i].busb; id_branch = br_tab[i].br;
      #1;
      check($sformatf("br[%0d] branch_fwd_a", i), {31'd0, branch_fwd_a}, {31'd0, br_tab[i].fwd_a});
      check($sformatf("br[%0d] branch_fwd_b", i), {31'd0, branch_fwd_b}, {31'd0, br_tab[i].fwd_b});
      check($sformatf("br[%0d] branch_ok", i), {31'd0, branch_ok}, {31'd0, br_tab[i].ok});
      check($sformatf("br[%0d] branch_bubble", i), {31'd0, branch_bubble}, {31'd0, br_tab[i].bubble});
    end

    // EX match resolves after one clock: the instruction moves to MEM and becomes forwardable.
    id_branch = 1'b0;
    ex_alu_a = 32'h00000040; ex_alu_b = '0; ex_aluctr = 3'b000;
    ex_rw = 5'd7; ex_regwr = 1'b1; ex_memtoreg = 1'b0;
    id_ra = 5'd7; id_rb = 5'd1; id_busa = 32'h0; id_busb = 32'h00000040; id_branch = 1'b1;
    #1;
    check("seq stall branch_bubble", {31'd0, branch_bubble}, 32'd1);
    tick();
    ex_regwr = 1'b0; ex_rw = 5'd0;
    #1;
    check("seq resolve branch_bubble", {31'd0, branch_bubble}, 32'd0);
    check("seq resolve branch_fwd_a", {31'd0, branch_fwd_a}, 32'd1);
    check("seq resolve branch_ok", {31'd0, branch_ok}, 32'd1);

    // Reset removes forwarding from the register.
    rst = 1'b0;
    #1;
    check("reset clears branch_fwd_a", {31'd0, branch_fwd_a}, 32'd0);
    check("reset branch_ok from raw operands", {31'd0, branch_ok}, 32'd0);
    rst = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
